// File: rtl/fsm_step_arbiter_if.sv
`default_nettype none
// ============================================================================
// fsm_step_arbiter_if : requester and step-sequencer signals of fsm_step_arbiter
// Revision 1.0
// ============================================================================
interface fsm_step_arbiter_if #(
  parameter int NREQ = 4,
  parameter int DW   = 4
);
  logic [NREQ-1:0] req;
  logic [DW-1:0]   dwell;
  logic            skip;
  logic [2:0]      fsm_out;
  logic            start;
  logic            step2;
  logic            step3;
  logic [NREQ-1:0] gnt;
  logic            busy;
  logic            done;
  logic            err;

  modport master (
    output req, dwell, skip, fsm_out,
    input  start, step2, step3, gnt, busy, done, err
  );

  modport slave (
    input  req, dwell, skip, fsm_out,
    output start, step2, step3, gnt, busy, done, err
  );
endinterface
`default_nettype wire

// File: rtl/fsm_step_arbiter.sv
`default_nettype none
// ============================================================================
// fsm_step_arbiter : round-robin owner of one four-phase step sequencer; optional watchdog via FSM_ARB_WDOG_EN
// Revision 1.0
// ============================================================================
module fsm_step_arbiter #(
  parameter int NREQ       = 4,
  parameter int DW         = 4,
  parameter int WDOG_LIMIT = 8
) (
  input  wire                 clk,
  input  wire                 clr,
  fsm_step_arbiter_if.slave   bus
);
  localparam int         PW       = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [2:0] PH_IDLE  = 3'b001;
  localparam logic [2:0] PH_STEP  = 3'b010;
  localparam logic [2:0] PH_S2    = 3'b100;

  if (NREQ < 2 || NREQ > 8 || DW < 1 || WDOG_LIMIT < 1) begin : g_bad_param
    $error("fsm_step_arbiter: parameter out of range");
  end

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LAUNCH  = 3'd1,
    WAIT_S2 = 3'd2,
    DWELL   = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t          state;
  logic [NREQ-1:0] gnt_q;
  logic [PW-1:0]   gnt_idx;
  logic [PW-1:0]   ptr;
  logic [DW-1:0]   dw_l;
  logic            sk_l;
  logic [DW-1:0]   cnt;
  logic            start_q;
  logic            step2_q;
  logic            step3_q;
  logic            busy_q;
  logic            done_q;
  logic [PW-1:0]   win_idx;
  logic [PW-1:0]   cand;

`ifdef FSM_ARB_WDOG_EN
  localparam int          WW      = $clog2(WDOG_LIMIT + 1);
  localparam logic [WW-1:0] WD_LAST = WW'(WDOG_LIMIT - 1);
  logic [WW-1:0] wd_cnt;
  logic          err_q;
  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

  // Descending scan so the candidate nearest to ptr+1 is the last one written.
  always_comb begin
    win_idx = '0;
    cand    = '0;
    for (int k = NREQ; k >= 1; k--) begin
      cand = PW'((int'(ptr) + k) % NREQ);
      if (bus.req[cand]) win_idx = cand;
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state   <= IDLE;
      gnt_q   <= '0;
      gnt_idx <= '0;
      ptr     <= PW'(NREQ - 1);
      dw_l    <= '0;
      sk_l    <= 1'b0;
      cnt     <= '0;
      start_q <= 1'b0;
      step2_q <= 1'b0;
      step3_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef FSM_ARB_WDOG_EN
      wd_cnt  <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
`ifdef FSM_ARB_WDOG_EN
      err_q  <= 1'b0;
      wd_cnt <= '0;
`endif
      case (state)
        IDLE: begin
          if ((|bus.req) && bus.fsm_out == PH_IDLE) begin
            state   <= LAUNCH;
            gnt_q   <= NREQ'(1) << win_idx;
            gnt_idx <= win_idx;
            dw_l    <= bus.dwell;
            sk_l    <= bus.skip;
            start_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        LAUNCH: begin
          if (bus.fsm_out == PH_STEP) begin
            state   <= WAIT_S2;
            start_q <= 1'b0;
            step2_q <= ~sk_l;
          end
`ifdef FSM_ARB_WDOG_EN
          else if (wd_cnt == WD_LAST) begin
            state   <= IDLE;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
            gnt_q   <= '0;
            ptr     <= gnt_idx;
            err_q   <= 1'b1;
          end else begin
            wd_cnt  <= wd_cnt + 1'b1;
          end
`endif
        end
        WAIT_S2: begin
          if (bus.fsm_out == PH_S2) begin
            step2_q <= 1'b0;
            if (sk_l) begin
              state  <= DONE;
              done_q <= 1'b1;
            end else begin
              state   <= DWELL;
              cnt     <= dw_l;
              step3_q <= (dw_l == '0);
            end
          end
`ifdef FSM_ARB_WDOG_EN
          else if (wd_cnt == WD_LAST) begin
            state   <= IDLE;
            step2_q <= 1'b0;
            busy_q  <= 1'b0;
            gnt_q   <= '0;
            ptr     <= gnt_idx;
            err_q   <= 1'b1;
          end else begin
            wd_cnt  <= wd_cnt + 1'b1;
          end
`endif
        end
        DWELL: begin
          // step3 is pre-registered so it is high exactly in the cnt==0 cycle.
          if (cnt == '0) begin
            state   <= DONE;
            step3_q <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            cnt     <= cnt - 1'b1;
            step3_q <= (cnt == DW'(1));
          end
        end
        DONE: begin
          state  <= IDLE;
          done_q <= 1'b0;
          busy_q <= 1'b0;
          gnt_q  <= '0;
          ptr    <= gnt_idx;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.start = start_q;
  assign bus.step2 = step2_q;
  assign bus.step3 = step3_q;
  assign bus.gnt   = gnt_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;

endmodule
`default_nettype wire

// File: tb/tb_fsm_step_arbiter.sv
`default_nettype none
// ============================================================================
// tb_fsm_step_arbiter : directed bench with a behavioural four-phase sequencer
// Revision 1.0
// ============================================================================
module tb_fsm_step_arbiter;
  logic clk = 1'b0;
  logic clr = 1'b0;
  logic seq_rst = 1'b1;
  logic force_en = 1'b0;
  logic [2:0] force_val = 3'b001;
  logic [2:0] seq_q;
  int n_vec = 0;
  int n_fail = 0;
  bit ok;

  always #5 clk = ~clk;

  fsm_step_arbiter_if #(.NREQ(4), .DW(4)) bus ();

  fsm_step_arbiter #(.NREQ(4), .DW(4), .WDOG_LIMIT(8)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus.slave)
  );

  // Sequencer: 001 -start-> 010 -> 100 -step2-> 111 -step3-> 001; 100 without step2 -> 001.
  always_ff @(posedge clk) begin
    if (seq_rst || force_en) seq_q <= 3'b001;
    else begin
      case (seq_q)
        3'b001:  if (bus.start) seq_q <= 3'b010;
        3'b010:  seq_q <= 3'b100;
        3'b100:  seq_q <= bus.step2 ? 3'b111 : 3'b001;
        3'b111:  if (bus.step3) seq_q <= 3'b001;
        default: seq_q <= 3'b001;
      endcase
    end
  end
  assign bus.fsm_out = force_en ? force_val : seq_q;

  typedef struct {
    logic [3:0] req;
    logic [3:0] dwell;
    bit         skip;
    bit         wdraw;
    logic [3:0] gnt;
    int         done_cyc;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic wait_done(input string nm, output bit got);
    got = 1'b0;
    for (int i = 0; i < 64 && !got; i++) begin
      @(negedge clk);
      if (bus.done) got = 1'b1;
    end
    chk({nm, " done seen"}, {31'd0, got}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL global timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] fair_exp [5];
    fair_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    //          req      dwell  skip  wdraw gnt      done cycle
    tbl[0] = '{4'b0001, 4'd3,  1'b0, 1'b1, 4'b0001, 8};
    tbl[1] = '{4'b0100, 4'd0,  1'b1, 1'b0, 4'b0100, 4};
    tbl[2] = '{4'b0011, 4'd0,  1'b0, 1'b0, 4'b0001, 5};
    tbl[3] = '{4'b1010, 4'd15, 1'b0, 1'b1, 4'b0010, 20};
    tbl[4] = '{4'b1010, 4'd1,  1'b1, 1'b0, 4'b1000, 4};
    tbl[5] = '{4'b0110, 4'd5,  1'b0, 1'b0, 4'b0010, 10};

    bus.req = '0; bus.dwell = '0; bus.skip = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("reset gnt",   {28'd0, bus.gnt}, 0);
    chk("reset start", {31'd0, bus.start}, 0);
    chk("reset step2", {31'd0, bus.step2}, 0);
    chk("reset step3", {31'd0, bus.step3}, 0);
    chk("reset busy",  {31'd0, bus.busy}, 0);
    chk("reset done",  {31'd0, bus.done}, 0);
    chk("reset err",   {31'd0, bus.err}, 0);
    clr = 1'b1;
    seq_rst = 1'b0;
    @(negedge clk);

    // Table: every output checked each cycle from grant to return to IDLE.
    for (int t = 0; t < 6; t++) begin
      bus.req = tbl[t].req; bus.dwell = tbl[t].dwell; bus.skip = tbl[t].skip;
      for (int c = 1; c <= tbl[t].done_cyc + 1; c++) begin
        @(negedge clk);
        chk($sformatf("t%0d c%0d gnt", t, c), {28'd0, bus.gnt},
            (c <= tbl[t].done_cyc) ? {28'd0, tbl[t].gnt} : 32'd0);
        chk($sformatf("t%0d c%0d busy", t, c), {31'd0, bus.busy}, (c <= tbl[t].done_cyc) ? 1 : 0);
        chk($sformatf("t%0d c%0d start", t, c), {31'd0, bus.start}, (c == 1 || c == 2) ? 1 : 0);
        chk($sformatf("t%0d c%0d step2", t, c), {31'd0, bus.step2}, (c == 3 && !tbl[t].skip) ? 1 : 0);
        chk($sformatf("t%0d c%0d step3", t, c), {31'd0, bus.step3},
            (!tbl[t].skip && c == tbl[t].done_cyc - 1) ? 1 : 0);
        chk($sformatf("t%0d c%0d done", t, c), {31'd0, bus.done}, (c == tbl[t].done_cyc) ? 1 : 0);
        chk($sformatf("t%0d c%0d ph111", t, c), {31'd0, bus.fsm_out == 3'b111},
            (!tbl[t].skip && c >= 4 && c <= tbl[t].done_cyc - 1) ? 1 : 0);
        if (c == 2) begin bus.dwell = ~bus.dwell; bus.skip = ~bus.skip; end
        if (c == 3 && tbl[t].wdraw) bus.req = tbl[t].req & ~tbl[t].gnt;
        if (c == tbl[t].done_cyc) bus.req = '0;
      end
    end

    // Busy sequencer: no grant while phase is not 001.
    force_en = 1'b1; force_val = 3'b100;
    bus.req = 4'b0001; bus.dwell = 4'd0; bus.skip = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("busyseq c%0d gnt", i), {28'd0, bus.gnt}, 0);
    end
    force_en = 1'b0;
    @(negedge clk);
    chk("busyseq release gnt", {28'd0, bus.gnt}, 32'h1);
    wait_done("busyseq", ok);
    bus.req = '0;
    @(negedge clk);

    // Reset in DWELL with the sequencer left stuck in 111.
    bus.req = 4'b0001; bus.dwell = 4'd10; bus.skip = 1'b0;
    for (int c = 1; c <= 5; c++) @(negedge clk);
    chk("middwell ph111", {29'd0, bus.fsm_out}, 32'h7);
    clr = 1'b0;
    #1;
    chk("middwell gnt",   {28'd0, bus.gnt}, 0);
    chk("middwell step3", {31'd0, bus.step3}, 0);
    chk("middwell busy",  {31'd0, bus.busy}, 0);
    chk("middwell done",  {31'd0, bus.done}, 0);
    @(negedge clk);
    clr = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("middwell hold c%0d gnt", i), {28'd0, bus.gnt}, 0);
    end
    seq_rst = 1'b1;
    @(negedge clk);
    seq_rst = 1'b0;
    chk("middwell seq reset gnt", {28'd0, bus.gnt}, 0);
    @(negedge clk);
    chk("middwell regrant gnt", {28'd0, bus.gnt}, 32'h1);
    wait_done("middwell", ok);
    bus.req = '0;
    @(negedge clk);

    // Fairness after a fresh reset: all four requesters held.
    clr = 1'b0;
    @(negedge clk);
    clr = 1'b1;
    bus.req = 4'b1111; bus.dwell = 4'd0; bus.skip = 1'b1;
    for (int g = 0; g < 5; g++) begin
      wait_done($sformatf("fair g%0d", g), ok);
      chk($sformatf("fair g%0d gnt", g), {28'd0, bus.gnt}, {28'd0, fair_exp[g]});
      if (g == 4) bus.req = '0;
    end
    @(negedge clk);

`ifdef FSM_ARB_WDOG_EN
    clr = 1'b0;
    @(negedge clk);
    clr = 1'b1;
    bus.req = 4'b0011; bus.dwell = 4'd0; bus.skip = 1'b1;
    force_en = 1'b1; force_val = 3'b001;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      chk($sformatf("wdog c%0d err", c), {31'd0, bus.err}, (c == 9) ? 1 : 0);
      chk($sformatf("wdog c%0d gnt", c), {28'd0, bus.gnt}, (c <= 8) ? 32'h1 : 32'h0);
      chk($sformatf("wdog c%0d done", c), {31'd0, bus.done}, 0);
    end
    force_en = 1'b0;
    @(negedge clk);
    chk("wdog next gnt", {28'd0, bus.gnt}, 32'h2);
    wait_done("wdog", ok);
    bus.req = '0;
    @(negedge clk);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
